rv2t_instruction_fetch: RTL and testbench

Instruction fetch stage of the RV2T core. Issues word reads to instruction memory, buffers the returned words, and presents IR/PC/is_compressed to the instruction decode stage through a valid/ready handshake. It also redirects on jumps and branches, flushing stale words. It sits between the memory arbiter and decode, driven by the core controller.

---
 rtl/rv2t_instruction_fetch.sv | 133 +++++++++++++
 tb/tb_rv2t_instruction_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv2t_instruction_fetch.sv
// RV2T fetch stage: single-outstanding word reads into a small buffer feeding decode.
// Define RV2T_FETCH_PREFETCH_EN for a BUF_DEPTH-entry prefetch FIFO; default is one holding entry.
module rv2t_instruction_fetch #(
  parameter int BUF_DEPTH   = 2,
  parameter int PC_BITWIDTH = 32,
  parameter int XLEN        = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_init,
  input  logic [PC_BITWIDTH-1:0] start_addr,
  input  logic                   jump_request,
  input  logic [PC_BITWIDTH-1:0] jump_addr,
  output logic                   mem_read_req,
  output logic [PC_BITWIDTH-1:0] mem_read_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_read_data,
  input  logic                   decode_ready,
  output logic                   enable_out,
  output logic [XLEN-3:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   is_compressed_out,
  output logic                   exception_instr_addr_misaligned
);

`ifdef RV2T_FETCH_PREFETCH_EN
  localparam int DEPTH    = BUF_DEPTH;
  localparam bit PREFETCH = 1'b1;
`else
  localparam int DEPTH    = BUF_DEPTH / BUF_DEPTH;  // always 1
  localparam bit PREFETCH = 1'b0;
`endif
  localparam int MEM_D = (DEPTH < 2) ? 2 : DEPTH;
  localparam int PTR_W = $clog2(MEM_D);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;
  state_t state, state_n;

  logic [PC_BITWIDTH-1:0] fetch_pc, drop_addr, target;
  logic                   drop;
  logic [XLEN-3:0]        ir_mem [MEM_D];
  logic [PC_BITWIDTH-1:0] pc_mem [MEM_D];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count, count_n;
  logic                   redirect, redirect_ok, issue, pending, push, pop;
  logic [XLEN-3:0]        ir_word;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign pop         = enable_out & decode_ready;
  assign redirect    = fetch_init | jump_request;
  assign target      = fetch_init ? start_addr : jump_addr;
  assign redirect_ok = fetch_init | (jump_addr[1:0] == 2'b00);

  // A full prefetch buffer may re-request in the very cycle decode pops an entry.
  assign issue   = drop | (state == REQ) | (PREFETCH && (state == STALL) && pop && !redirect);
  assign pending = issue & ~mem_read_ack;
  assign push    = issue & mem_read_ack & ~drop & ~redirect;
  assign ir_word = (mem_read_data[1:0] == 2'b11) ? mem_read_data[XLEN-1:2] : '1;

  assign mem_read_req      = issue;
  assign mem_read_addr     = issue ? (drop ? drop_addr : fetch_pc) : '0;
  assign enable_out        = (count != '0);
  assign IR_out            = ir_mem[rd_ptr];
  assign PC_out            = pc_mem[rd_ptr];
  assign is_compressed_out = 1'b0;

  always_comb begin
    count_n = count;
    if (redirect)          count_n = '0;
    else if (push && !pop) count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // While a discarded read is still outstanding the state just holds its post-redirect target.
  always_comb begin
    state_n = state;
    if (redirect) state_n = redirect_ok ? REQ : IDLE;
    else if (!drop) begin
      case (state)
        REQ:     if (mem_read_ack) state_n = (count_n < DEPTH_C) ? REQ : STALL;
        STALL:   state_n = (count_n < DEPTH_C) ? REQ : STALL;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc  <= '0;
      drop      <= 1'b0;
      drop_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      exception_instr_addr_misaligned <= 1'b0;
      for (int i = 0; i < MEM_D; i++) begin
        ir_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else begin
      count <= count_n;
      exception_instr_addr_misaligned <= redirect & ~redirect_ok;
      if (redirect) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        drop      <= pending;
        drop_addr <= mem_read_addr;
        if (redirect_ok) fetch_pc <= {target[PC_BITWIDTH-1:2], 2'b00};
      end else begin
        if (drop && mem_read_ack) drop <= 1'b0;
        if (push) begin
          ir_mem[wr_ptr] <= ir_word;
          pc_mem[wr_ptr] <= fetch_pc;
          wr_ptr         <= nxt(wr_ptr);
          fetch_pc       <= fetch_pc + PC_BITWIDTH'(4);
        end
        if (pop) rd_ptr <= nxt(rd_ptr);
      end
    end
  end

endmodule

// File: tb/tb_rv2t_instruction_fetch.sv
// Bench for rv2t_instruction_fetch: directed timing steps plus a randomized run checked
// against an address-indexed memory model and an in-order expected-PC counter.
module tb_rv2t_instruction_fetch;

`ifdef RV2T_FETCH_PREFETCH_EN
  localparam int SPACING = 1;
`else
  localparam int SPACING = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n, fetch_init, jump_request, decode_ready;
  logic [31:0] start_addr, jump_addr;
  logic        mem_read_req, mem_read_ack;
  logic [31:0] mem_read_addr, mem_read_data;
  logic        enable_out, is_compressed_out, exception_instr_addr_misaligned;
  logic [29:0] IR_out;
  logic [31:0] PC_out;

  int          n_cmp = 0, n_bad = 0, cyc = 0, n_pop = 0;
  int          ack_mode = 2;
  logic        man_ack = 1'b0, rnd_ack = 1'b0;
  logic [31:0] exp_pc = '0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  int          pop_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] mem_ovr [logic [31:0]];

  rv2t_instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .fetch_init(fetch_init), .start_addr(start_addr),
    .jump_request(jump_request), .jump_addr(jump_addr),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_ack(mem_read_ack), .mem_read_data(mem_read_data),
    .decode_ready(decode_ready), .enable_out(enable_out), .IR_out(IR_out), .PC_out(PC_out),
    .is_compressed_out(is_compressed_out),
    .exception_instr_addr_misaligned(exception_instr_addr_misaligned)
  );

  always #5 clk = ~clk;

  // Instruction memory: hashed contents, a few non-32-bit encodings, plus directed overrides.
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    return {h[31:2], (a[6:2] == 5'd9) ? 2'b00 : 2'b11};
  endfunction

  function automatic logic [29:0] exp_ir(input logic [31:0] pc);
    logic [31:0] w;
    w = word(pc);
    return (w[1:0] == 2'b11) ? w[31:2] : 30'h3FFFFFFF;
  endfunction

  assign mem_read_data = word(mem_read_addr);
  assign mem_read_ack  = (ack_mode == 0) ? mem_read_req :
                         (ack_mode == 1) ? (mem_read_req & rnd_ack) : man_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluate the current cycle: decode acceptances against the model, request protocol.
  task automatic settle();
    rnd_ack = ($urandom_range(0, 3) != 0);
    #1;
    if (reset_n && !fetch_init && !jump_request && enable_out === 1'b1 && decode_ready) begin
      check("pop_pc", PC_out, exp_pc);
      check("pop_ir", IR_out, exp_ir(exp_pc));
      check("pop_is_c", is_compressed_out, 0);
      pop_cyc.push_back(cyc);
      pop_pc.push_back(PC_out);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (prev_pend) begin
      check("req_hold", mem_read_req, 1);
      check("addr_hold", mem_read_addr, prev_addr);
    end
    if (reset_n && mem_read_req) check("addr_align", mem_read_addr[1:0], 0);
    prev_pend = reset_n && mem_read_req && !mem_read_ack;
    prev_addr = mem_read_addr;
    if (reset_n) begin
      if (fetch_init) exp_pc = {start_addr[31:2], 2'b00};
      else if (jump_request && jump_addr[1:0] == 2'b00) exp_pc = jump_addr;
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
    fetch_init   = 1'b0;
    jump_request = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      adv();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fetch_init = 1'b0; jump_request = 1'b0; decode_ready = 1'b0;
    run(2);
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem_read_req, 0);
    check({tag, "_addr"}, mem_read_addr, 0);
    check({tag, "_en"}, enable_out, 0);
    check({tag, "_ir"}, IR_out, 0);
    check({tag, "_pc"}, PC_out, 0);
    check({tag, "_is_c"}, is_compressed_out, 0);
    check({tag, "_exc"}, exception_instr_addr_misaligned, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, p0, r;
    start_addr = '0; jump_addr = '0; fetch_init = 1'b0; jump_request = 1'b0;
    decode_ready = 1'b0; reset_n = 1'b0;
    mem_ovr[32'h300] = 32'h00500093;
    mem_ovr[32'h500] = 32'h00004501;

    // Reset state
    do_reset();
    settle();
    check_all_zero("reset");
    adv();

    // Sequential fetch from 0x100, zero-wait memory, decode always ready
    ack_mode = 0; decode_ready = 1'b1;
    pop_cyc.delete(); pop_pc.delete();
    fetch_init = 1'b1; start_addr = 32'h100; n0 = cyc;
    settle(); adv();
    settle();
    check("seq_req", mem_read_req, 1);
    check("seq_addr", mem_read_addr, 32'h100);
    adv();
    run(8);
    check("seq_npops", pop_cyc.size() >= 3, 1);
    if (pop_cyc.size() >= 3) begin
      check("seq_first_cyc", pop_cyc[0], n0 + 2);
      check("seq_space1", pop_cyc[1] - pop_cyc[0], SPACING);
      check("seq_space2", pop_cyc[2] - pop_cyc[1], SPACING);
      check("seq_pc0", pop_pc[0], 32'h100);
      check("seq_pc1", pop_pc[1], 32'h104);
      check("seq_pc2", pop_pc[2], 32'h108);
    end

    // Decode stall: head entry held, requests stop once the buffer is full
    decode_ready = 1'b0;
    fetch_init = 1'b1; start_addr = 32'h300;
    settle(); adv();
    run(1);
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_en", enable_out, 1);
      check("stall_ir", IR_out, 30'h00140024);
      check("stall_pc", PC_out, 32'h300);
      if (i == 4) check("stall_req_off", mem_read_req, 0);
      adv();
    end
    decode_ready = 1'b1; p0 = n_pop;
    run(6);
    check("stall_release_pops", (n_pop - p0) >= 3, 1);

    // Redirect while a read is pending: old ack discarded, then fetch from 0x200
    do_reset();
    ack_mode = 2; man_ack = 1'b0; decode_ready = 1'b0;
    fetch_init = 1'b1; start_addr = 32'h400;
    settle(); adv();
    jump_request = 1'b1; jump_addr = 32'h200;
    settle();
    check("rdr_req", mem_read_req, 1);
    check("rdr_addr", mem_read_addr, 32'h400);
    adv();
    decode_ready = 1'b1;
    settle();
    check("rdr_en_off", enable_out, 0);
    check("rdr_hold_addr", mem_read_addr, 32'h400);
    adv();
    run(1);
    man_ack = 1'b1;
    settle(); adv();
    man_ack = 1'b0; ack_mode = 0; pop_pc.delete();
    settle();
    check("rdr_new_req", mem_read_req, 1);
    check("rdr_new_addr", mem_read_addr, 32'h200);
    adv();
    run(4);
    check("rdr_npops", pop_pc.size() >= 1, 1);
    if (pop_pc.size() >= 1) check("rdr_first_pc", pop_pc[0], 32'h200);

    // Misaligned target with no request pending
    do_reset();
    ack_mode = 0; decode_ready = 1'b0;
    fetch_init = 1'b1; start_addr = 32'h700;
    settle(); adv();
    run(4);
    jump_request = 1'b1; jump_addr = 32'h202;
    settle();
    check("mis_pre_req", mem_read_req, 0);
    adv();
    settle();
    check("mis_exc", exception_instr_addr_misaligned, 1);
    check("mis_en", enable_out, 0);
    check("mis_req", mem_read_req, 0);
    adv();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("mis_exc_pulse", exception_instr_addr_misaligned, 0);
      check("mis_idle_req", mem_read_req, 0);
      adv();
    end

    // Non-32-bit encoding becomes all ones
    decode_ready = 1'b1;
    fetch_init = 1'b1; start_addr = 32'h500;
    settle(); adv();
    settle();
    check("c16_req", mem_read_req, 1);
    check("c16_addr", mem_read_addr, 32'h500);
    adv();
    settle();
    check("c16_en", enable_out, 1);
    check("c16_pc", PC_out, 32'h500);
    check("c16_ir", IR_out, 30'h3FFFFFFF);
    check("c16_is_c", is_compressed_out, 0);
    adv();
    run(4);

    // Reset mid-request; a late ack must be ignored
    do_reset();
    ack_mode = 2; man_ack = 1'b0; decode_ready = 1'b1;
    fetch_init = 1'b1; start_addr = 32'h600;
    settle(); adv();
    reset_n = 1'b0;
    settle();
    check("rst_req_before", mem_read_req, 1);
    adv();
    reset_n = 1'b1; man_ack = 1'b1;
    settle();
    check_all_zero("rst_mid");
    adv();
    man_ack = 1'b0;
    settle();
    check("rst_late_req", mem_read_req, 0);
    check("rst_late_en", enable_out, 0);
    adv();

    // Randomized traffic: random ack latency, decode back-pressure, redirects, wrap-around
    do_reset();
    ack_mode = 1; decode_ready = 1'b0;
    fetch_init = 1'b1; start_addr = $urandom & 32'h0000FFFC;
    settle(); adv();
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        jump_request = 1'b1;
        jump_addr = (r == 0) ? 32'hFFFFFFF0 : ($urandom & 32'h0000FFFC);
      end else if (r == 3) begin
        jump_request = 1'b1;
        jump_addr = ($urandom & 32'h0000FFFC) | 32'h2;
      end else if (r == 4) begin
        fetch_init = 1'b1;
        start_addr = $urandom & 32'h0000FFFC;
      end
      decode_ready = (r < 5) ? 1'b0 : ($urandom_range(0, 2) != 0);
      settle(); adv();
    end
    check("rand_progress", (n_pop - p0) > 300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
